// File: rtl/ad_reg_arbiter_pkg.sv
// Shared constants for the A/D register-pair arbiter: FSM encodings,
// register target codes and the default data width.
package ad_reg_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t GRANT  = 2'd1;
    localparam state_t LOCKED = 2'd2;

    localparam logic REG_A = 1'b0;
    localparam logic REG_D = 1'b1;

    localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: the first set request at or above ptr,
// wrapping modulo N, is reported as idx; valid is high when any request is set.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    // rot[k] is the request that sits k places after ptr.
    logic [N-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = req[PTR_W'((int'(ptr) + gi) % N)];
        end
    endgenerate

    always_comb begin
        idx   = '0;
        valid = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = PTR_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/ad_reg_arbiter.sv
// Round-robin arbiter sharing one A/D register pair between NUM_REQ writers,
// with an optional lock that keeps ownership for back-to-back writes.
module ad_reg_arbiter
    import ad_reg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_sel,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_lock,
    input  logic                     clr,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         a_out,
    output logic [WIDTH-1:0]         d_out,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0] owner_reg, owner_next;
    logic [WIDTH-1:0] a_reg, d_reg;

    logic [WIDTH-1:0] data_arr [NUM_REQ];
    logic [PTR_W-1:0] win_idx;
    logic             win_valid;
    logic             wr_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_reg),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        gnt         = '0;
        wr_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_valid && !clr) begin
                    owner_next = win_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // A clear drops the pending write and leaves rr_ptr alone,
                // so the same requester wins the retry.
                if (clr) begin
                    state_next = IDLE;
                end else begin
                    gnt[owner_reg] = 1'b1;
                    wr_en          = 1'b1;
                    rr_ptr_next    = (owner_reg == LAST) ? '0 : owner_reg + PTR_W'(1);
                    state_next     = req_lock[owner_reg] ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (clr) begin
                    state_next = IDLE;
                end else begin
                    if (req[owner_reg]) begin
                        gnt[owner_reg] = 1'b1;
                        wr_en          = 1'b1;
                    end
                    state_next = req_lock[owner_reg] ? LOCKED : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg <= '0;
            d_reg <= '0;
        end else if (clr) begin
            a_reg <= '0;
            d_reg <= '0;
        end else if (wr_en) begin
            if (req_sel[owner_reg] == REG_D) begin
                d_reg <= data_arr[owner_reg];
            end else begin
                a_reg <= data_arr[owner_reg];
            end
        end
    end

    assign a_out = a_reg;
    assign d_out = d_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_ad_reg_arbiter.sv
// Directed bench for ad_reg_arbiter: reset, round-robin, single write,
// clr collision, lock burst and asynchronous reset during a locked burst.
module tb_ad_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_sel;
    logic [63:0] req_data;
    logic [3:0]  req_lock;
    logic        clr;
    logic [3:0]  gnt;
    logic [15:0] a_out;
    logic [15:0] d_out;
    logic        busy;

    int tests    = 0;
    int failures = 0;

    ad_reg_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_sel  (req_sel),
        .req_data (req_data),
        .req_lock (req_lock),
        .clr      (clr),
        .gnt      (gnt),
        .a_out    (a_out),
        .d_out    (d_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int i, input logic [15:0] v);
        req_data[i*16 +: 16] = v;
    endtask

    initial begin
        reset    = 1'b0;
        req      = 4'b1111;
        req_sel  = 4'b0000;
        req_lock = 4'b0000;
        clr      = 1'b0;
        req_data = '0;
        for (int i = 0; i < 4; i++) set_data(i, 16'(i + 1));

        // Reset held with every requester active
        repeat (2) @(posedge clk);
        #2;
        chk("rst_a", 32'(a_out), 32'h0);
        chk("rst_d", 32'(d_out), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;

        // Round robin: grants 0,1,2,3,0 with a_out 1,2,3,4,1
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
            chk($sformatf("rr_busy%0d", k), 32'(busy), 32'h1);
            if (k == 4) req = 4'b0000;
            step();
            chk($sformatf("rr_a%0d", k), 32'(a_out), 32'((k % 4) + 1));
            chk($sformatf("rr_idle_gnt%0d", k), 32'(gnt), 32'h0);
        end
        chk("rr_d", 32'(d_out), 32'h0);
        $display("[TB] round-robin sequence done a=%h d=%h", a_out, d_out);

        // Single write of BEEF to D from requester 2 (rr_ptr=1)
        req_sel = 4'b0100;
        set_data(2, 16'hBEEF);
        req = 4'b0100;
        step();
        chk("sw_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        step();
        chk("sw_d", 32'(d_out), 32'hBEEF);
        chk("sw_a", 32'(a_out), 32'h1);
        $display("[TB] single write d=%h a=%h", d_out, a_out);

        // clr during GRANT of a 1234 write to D from requester 3 (rr_ptr=3)
        req_sel = 4'b1000;
        set_data(3, 16'h1234);
        req = 4'b1000;
        step();
        chk("clr_gnt_pre", 32'(gnt), 32'h8);
        clr = 1'b1;
        #1;
        chk("clr_gnt_forced", 32'(gnt), 32'h0);
        step();
        chk("clr_d", 32'(d_out), 32'h0);
        chk("clr_a", 32'(a_out), 32'h0);
        chk("clr_busy", 32'(busy), 32'h0);
        clr = 1'b0;
        step();
        chk("clr_regnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        step();
        chk("clr_d_after", 32'(d_out), 32'h1234);
        $display("[TB] clr collision retried d=%h", d_out);

        // Lock burst by requester 1 while requester 3 waits (rr_ptr=0)
        req_sel  = 4'b0000;
        req_lock = 4'b0010;
        set_data(1, 16'h0010);
        set_data(3, 16'h0033);
        req = 4'b1010;
        step();
        chk("lk_gnt0", 32'(gnt), 32'h2);
        step();
        chk("lk_a0", 32'(a_out), 32'h0010);
        chk("lk_gnt1", 32'(gnt), 32'h2);
        chk("lk_busy1", 32'(busy), 32'h1);
        set_data(1, 16'h0011);
        step();
        chk("lk_a1", 32'(a_out), 32'h0011);
        chk("lk_gnt2", 32'(gnt), 32'h2);
        set_data(1, 16'h0012);
        req_lock = 4'b0000;
        #1;
        chk("lk_gnt2_unlock", 32'(gnt), 32'h2);
        step();
        chk("lk_a2", 32'(a_out), 32'h0012);
        chk("lk_gnt_idle", 32'(gnt), 32'h0);
        chk("lk_busy_idle", 32'(busy), 32'h0);
        req = 4'b1000;
        step();
        chk("lk_gnt3", 32'(gnt), 32'h8);
        req = 4'b0000;
        step();
        chk("lk_a3", 32'(a_out), 32'h0033);
        chk("lk_d3", 32'(d_out), 32'h1234);
        $display("[TB] lock burst done a=%h d=%h", a_out, d_out);

        // Asynchronous reset in LOCKED (requester 0, rr_ptr=0 beforehand)
        req_sel  = 4'b0001;
        req_lock = 4'b0001;
        set_data(0, 16'h0055);
        req = 4'b0001;
        step();
        chk("ar_gnt", 32'(gnt), 32'h1);
        step();
        chk("ar_d_locked", 32'(d_out), 32'h0055);
        chk("ar_busy_locked", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_a", 32'(a_out), 32'h0);
        chk("ar_d", 32'(d_out), 32'h0);
        chk("ar_gnt_clr", 32'(gnt), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        // Without the reset rr_ptr would be 1 and requester 1 would win
        req_lock = 4'b0000;
        req_sel  = 4'b0000;
        set_data(0, 16'h0066);
        req = 4'b0011;
        #1;
        reset = 1'b1;
        step();
        chk("ar_ptr_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        chk("ar_a_after", 32'(a_out), 32'h0066);
        $display("[TB] async reset recovery a=%h", a_out);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/ad_reg_arbiter.md
Name: ad_reg_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one A/D register pair (two 16-bit load-enabled registers) between NUM_REQ requesters.
- Each requester raises a request naming a target register and a data word. The block grants one requester at a time and commits its write.
- A lock option lets a requester keep ownership for back-to-back writes.
- Sits between the CPU-side/DMA-side writers and the A/D register pair.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, register data width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester write request; held until granted
- req_sel  input  NUM_REQ  per-requester target: 0 = A register, 1 = D register
- req_data  input  NUM_REQ*WIDTH  per-requester write data; slice i = bits [i*WIDTH +: WIDTH]
- req_lock  input  NUM_REQ  per-requester lock; when high at grant, the requester keeps ownership
- clr  input  1  synchronous clear of both registers
- gnt  output  NUM_REQ  one-hot grant; high in the cycle its write commits
- a_out  output  WIDTH  A register contents
- d_out  output  WIDTH  D register contents
- busy  output  1  high while state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - a_out=0, d_out=0, gnt=0, busy=0
  - state=IDLE, rr_ptr=0, owner=0
- States: IDLE, GRANT, LOCKED.
- IDLE:
  - If any req is high and clr=0, pick the winner: the first requester i with req[i]=1, searching upward from rr_ptr and wrapping modulo NUM_REQ.
  - Register owner=winner and go to GRANT.
  - If no req is high, stay in IDLE.
- GRANT (one cycle):
  - gnt[owner]=1.
  - At the end of the cycle, write req_data[owner] into A (req_sel=0) or D (req_sel=1).
  - Set rr_ptr=(owner+1) mod NUM_REQ.
  - Next state: LOCKED if req_lock[owner]=1, else IDLE.
- LOCKED:
  - Each cycle with req[owner]=1, assert gnt[owner]=1 and commit that cycle's data and target (one write per cycle).
  - Stay in LOCKED while req_lock[owner]=1.
  - When req_lock[owner]=0, return to IDLE. The write in that cycle is still committed if req[owner]=1.
  - Other requesters are never granted while in LOCKED.
- Latency:
  - Request sampled in IDLE at cycle t; gnt high at t+1; new value visible on a_out/d_out at t+2.
  - Minimum spacing between unlocked grants is 2 cycles (IDLE, GRANT).
- Requester handshake:
  - Hold req, req_sel and req_data stable from assertion until the cycle gnt is seen.
  - Drop req in the cycle after gnt unless another write is intended.
- clr:
  - Has priority over any write: a_out=d_out=0 at the next edge.
  - In GRANT or LOCKED, the pending write is dropped, gnt is forced to 0 and state returns to IDLE.
  - rr_ptr is unchanged, so the same requester still wins the next arbitration.
- gnt is registered-state decoded: never more than one bit high; always 0 in IDLE.
- Wrap-around: with rr_ptr = NUM_REQ-1 and only req[0] high, requester 0 wins.
- Mid-operation reset clears everything immediately. No write is committed in that cycle.
- Writes to A never disturb D, and vice versa.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, GRANT=2'd1, LOCKED=2'd2
  - REG_A=1'b0, REG_D=1'b1
  - default WIDTH
- One natural sub-module: rr_pick, a combinational round-robin priority search (req vector plus rr_ptr to winner index and a valid flag). It is reused by future bus arbiters.
- Storage is two WIDTH-bit load-enabled registers with the asynchronous active-low reset.

Test Plan:
- Reset check: hold reset=0 with req=4'b1111 -> a_out=0, d_out=0, gnt=0, busy=0. After release, the first grant goes to requester 0.
- Single write: req[2]=1, req_sel[2]=1, data 16'hBEEF -> gnt=4'b0100 exactly one cycle later; d_out=16'hBEEF the following cycle; a_out unchanged at 0.
- Round-robin fairness: all four requesters continuously requesting A with distinct data 16'h0001..16'h0004 -> grant order 0,1,2,3,0. a_out follows 1,2,3,4,1, with a grant every 2 cycles.
- Lock burst:
  - req[1] with req_lock[1]=1 writes 16'h0010, 16'h0011, 16'h0012 to A in consecutive cycles while req[3] is also high.
  - Expect gnt=4'b0010 for 3 cycles and requester 3 unserved.
  - Drop the lock -> requester 3 is granted 2 cycles later.
- clr collision: assert clr in the GRANT cycle of a 16'h1234 write to D -> gnt=0, d_out=0, state IDLE. The same requester is re-granted and d_out=16'h1234 afterwards.
- Async reset mid-lock: pull reset low between clock edges during LOCKED -> outputs clear without waiting for a clock edge; busy=0; rr_ptr=0.
